instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Parametrised instruction fetch unit with a prefetch queue, replacing the single-register PC/incrementor/mux fetch path. It owns the fetch PC, issues sequential requests to a 1-cycle-latency instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It presents them to decode over a valid/ready handshake. Branch redirects support absolute and PC-relative modes and flush all buffered and in-flight fetches.

## Interface
- ADDR_W, 16, width of PC and instruction-memory address
- INSTR_W, 9, instruction width
- DEPTH, 4, prefetch queue entries; power of two, >= 2
- INC, 1, PC increment per sequential fetch
- RESET_ADDR, 0, fetch PC after reset
- CLK  in  1  clock; all state updates on rising edge
- reset_ctrl_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDR_W  fetch address; equals fetch PC
- imem_rdata  in  INSTR_W  instruction for the request issued in the previous cycle
- dec_valid  out  1  queue head valid
- dec_instr  out  INSTR_W  head instruction
- dec_pc  out  ADDR_W  head instruction's PC
- dec_ready  in  1  decode accepts head
- branch_ctrl  in  1  redirect request, single-cycle strobe
- branch_mode  in  1  0 = absolute, 1 = PC-relative
- branch_pc  in  ADDR_W  PC of the branching instruction; used in relative mode
- branch_target  in  ADDR_W  absolute target (mode 0) or two's-complement offset (mode 1)
- halt_ctrl  in  1  level; suppresses new requests while high

## Operation
- State: fetch_pc, queue storage {pc, instr} x DEPTH, read/write pointers, count (0..DEPTH), inflight flag with its address.
- Issue: imem_req = !halt_ctrl && !branch_ctrl && (count + inflight < DEPTH). On issue, fetch_pc <= fetch_pc + INC and inflight <= 1 with address latched. Otherwise inflight <= 0.
- Return: if inflight is set and no flush occurs this cycle, {latched addr, imem_rdata} is written at the queue tail.
- Dequeue: when dec_valid && dec_ready, pop the head. Push and pop in the same cycle leave count unchanged.
- Redirect: when branch_ctrl is high:
  - count <= 0 and pointers reset.
  - Any returning in-flight data is dropped; inflight <= 0.
  - fetch_pc <= target, where target = branch_target (mode 0) or branch_pc + branch_target, modulo 2^ADDR_W (mode 1).
  - A pop in the same cycle is ignored; the flush wins.
- Arithmetic: all PC sums wrap modulo 2^ADDR_W. After 2^ADDR_W - INC, fetch continues from the wrapped value with no error.
- Halt: halt_ctrl only blocks issue. An in-flight return still lands, and the queue continues draining to decode. A branch during halt updates fetch_pc and flushes the queue.
- Full: no request is issued when count + inflight = DEPTH, so the queue never overflows and a return never finds the queue full.
- Empty: dec_valid = (count != 0). dec_instr and dec_pc are don't-care when dec_valid = 0.

## Timing
- Reset (asynchronous assert): fetch_pc = RESET_ADDR, count = 0, inflight = 0, imem_req = 0, dec_valid = 0, dec_instr = 0, dec_pc = 0.
- Latency: a request issued in cycle c lands in the queue at the end of c+1. With an empty queue, dec_valid is high in c+2.
- First fetch: imem_req is high in the first cycle after reset_ctrl_n deasserts (if halt_ctrl = 0). The first dec_valid follows 2 cycles later.
- Branch at cycle t:
  - imem_req = 0 in t.
  - Request for the target in t+1.
  - Target instruction appears at dec_valid in t+3.
- Throughput: with dec_ready held high and no branch, one instruction per cycle sustained from the third cycle on.
- Handshake: while dec_valid = 1 and dec_ready = 0, dec_instr and dec_pc are held stable.

## Test plan
- Reset/sequential: release reset with RESET_ADDR=0 and dec_ready=1.
  - Required: imem_addr 0,1,2,... on consecutive cycles.
  - Required: dec_pc 0,1,2,... beginning 2 cycles after the first request, with dec_instr matching the memory model.
- Backpressure/full: hold dec_ready=0.
  - Required: exactly DEPTH (4) instructions enqueued, then imem_req=0.
  - Required: on raising dec_ready, pops of PCs 0..3 in order with no loss or duplication.
- Absolute branch: assert branch_ctrl with mode 0, target 0x0040, while the queue holds 3 entries and one request is in flight.
  - Required: next dec_pc = 0x0040 appears 3 cycles later, with no stale PCs delivered.
- Relative branch: branch_pc=0x0010 with offset 0xFFFC (-4).
  - Required: next dec_pc = 0x000C.
  - Also: branch_pc=0xFFFE with offset 0x0004 → dec_pc = 0x0002 (wrap).
- Simultaneous events: branch_ctrl together with dec_valid && dec_ready.
  - Required: flush wins and count=0 the next cycle.
  - Separately: halt_ctrl high with one request in flight → that instruction is delivered, then imem_req stays 0.
- Mid-operation reset: pull reset_ctrl_n low mid-stream.
  - Required: dec_valid=0 and imem_req=0 immediately, without waiting for CLK.
  - Required: after release, fetch resumes at RESET_ADDR.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch feeding a DEPTH-entry prefetch queue toward decode.
// A branch (absolute or PC-relative) flushes queued and in-flight fetches and redirects the PC.
module instr_fetch_queue #(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       INSTR_W    = 9,
    parameter int unsigned       DEPTH      = 4,
    parameter int unsigned       INC        = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic               CLK,
    input  logic               reset_ctrl_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               dec_ready,
    input  logic               branch_ctrl,
    input  logic               branch_mode,
    input  logic [ADDR_W-1:0]  branch_pc,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt_ctrl
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t             r_queue [DEPTH];
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_addr;

    logic [CNT_W-1:0]   w_occupancy;
    logic               w_can_issue;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_target;
    entry_t             w_head;

    // An in-flight request already owns a queue slot, so it counts toward occupancy.
    assign w_occupancy = r_count + CNT_W'(r_inflight);
    assign w_can_issue = !halt_ctrl && !branch_ctrl && (w_occupancy < CNT_W'(DEPTH));
    assign w_push      = r_inflight && !branch_ctrl;
    assign w_pop       = dec_valid && dec_ready && !branch_ctrl;
    assign w_target    = branch_mode ? (branch_pc + branch_target) : branch_target;
    assign w_head      = r_queue[r_rd_ptr];

    // Reset gates the request combinationally so it drops without waiting for a clock edge.
    assign imem_req  = reset_ctrl_n && w_can_issue;
    assign imem_addr = r_fetch_pc;
    assign dec_valid = (r_count != '0);
    assign dec_instr = dec_valid ? w_head.instr : '0;
    assign dec_pc    = dec_valid ? w_head.pc    : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge reset_ctrl_n) begin
        if (!reset_ctrl_n) begin
            r_fetch_pc      <= RESET_ADDR;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else if (branch_ctrl) begin
            r_fetch_pc <= w_target;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_can_issue) begin
                r_fetch_pc      <= r_fetch_pc + ADDR_W'(INC);
                r_inflight_addr <= r_fetch_pc;
            end
            r_inflight <= w_can_issue;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: queue storage is deliberately not reset; the empty-queue output mask hides stale entries.
    always_ff @(posedge CLK) begin
        if (w_push) r_queue[r_wr_ptr] <= '{pc: r_inflight_addr, instr: imem_rdata};
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instr_fetch_queue;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 9;
    localparam int DEPTH   = 4;

    logic               CLK;
    logic               reset_ctrl_n;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dec_valid;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic               dec_ready;
    logic               branch_ctrl;
    logic               branch_mode;
    logic [ADDR_W-1:0]  branch_pc;
    logic [ADDR_W-1:0]  branch_target;
    logic               halt_ctrl;

    instr_fetch_queue #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .INC(1), .RESET_ADDR(16'h0000)
    ) dut (
        .CLK(CLK), .reset_ctrl_n(reset_ctrl_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready),
        .branch_ctrl(branch_ctrl), .branch_mode(branch_mode),
        .branch_pc(branch_pc), .branch_target(branch_target), .halt_ctrl(halt_ctrl)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    // Reference model: queue contents, fetch PC and the single outstanding request.
    ent_t              m_q[$];
    logic [ADDR_W-1:0] m_pc;
    int                m_infl;
    logic [ADDR_W-1:0] m_infl_addr;

    int n_vec = 0;
    int n_mis = 0;

    function automatic logic [INSTR_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = (32'(a) * 32'd37) ^ 32'h1A5 ^ (32'(a) >> 9);
        return t[INSTR_W-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_req();
        return !halt_ctrl && !branch_ctrl && ((m_q.size() + m_infl) < DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc        = '0;
        m_infl      = 0;
        m_infl_addr = '0;
    endtask

    task automatic model_step();
        logic req;
        req = model_req();
        if (branch_ctrl) begin
            m_q.delete();
            m_infl = 0;
            m_pc   = branch_mode ? ADDR_W'(branch_pc + branch_target) : branch_target;
        end else begin
            if (m_q.size() != 0 && dec_ready) void'(m_q.pop_front());
            if (m_infl != 0) m_q.push_back('{pc: m_infl_addr, instr: mem_f(m_infl_addr)});
            if (req) begin
                m_infl      = 1;
                m_infl_addr = m_pc;
                m_pc        = m_pc + ADDR_W'(1);
            end else begin
                m_infl = 0;
            end
        end
    endtask

    // Called just after a falling edge once the inputs for this cycle are driven.
    task automatic settle();
        logic exp_req;
        #1;
        exp_req = model_req();
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("dec_valid", 32'(dec_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("dec_pc", 32'(dec_pc), 32'(m_q[0].pc));
            check("dec_instr", 32'(dec_instr), 32'(m_q[0].instr));
        end
    endtask

    // Memory answers the DUT's actual request one cycle later; idle cycles get noise.
    task automatic advance();
        logic              req_q;
        logic [ADDR_W-1:0] addr_q;
        req_q  = imem_req;
        addr_q = imem_addr;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        imem_rdata = req_q ? mem_f(addr_q) : INSTR_W'($urandom);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic do_reset();
        reset_ctrl_n = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_pc", 32'(dec_pc), 32'd0);
        check("rst_dec_instr", 32'(dec_instr), 32'd0);
        repeat (2) @(negedge CLK);
        reset_ctrl_n = 1'b1;
        imem_rdata   = INSTR_W'($urandom);
        model_reset();
    endtask

    task automatic branch_to(input logic mode, input logic [ADDR_W-1:0] bpc,
                             input logic [ADDR_W-1:0] tgt);
        branch_ctrl   = 1'b1;
        branch_mode   = mode;
        branch_pc     = bpc;
        branch_target = tgt;
        settle();
        check("br_req_low", 32'(imem_req), 32'd0);
        advance();
        branch_ctrl = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_ctrl_n  = 1'b1;
        dec_ready     = 1'b1;
        branch_ctrl   = 1'b0;
        branch_mode   = 1'b0;
        branch_pc     = '0;
        branch_target = '0;
        halt_ctrl     = 1'b0;
        imem_rdata    = '0;
        #1;
        do_reset();

        // Sequential fetch from reset.
        settle();
        check("seq_addr0", 32'(imem_addr), 32'h0);
        advance();
        settle();
        check("seq_addr1", 32'(imem_addr), 32'h1);
        advance();
        settle();
        check("seq_first_valid", 32'(dec_valid), 32'd1);
        check("seq_pc0", 32'(dec_pc), 32'h0);
        check("seq_instr0", 32'(dec_instr), 32'h1A5);
        advance();
        settle();
        check("seq_pc1", 32'(dec_pc), 32'h1);
        check("seq_instr1", 32'(dec_instr), 32'h180);
        advance();
        repeat (6) tick();

        // Backpressure: queue fills to DEPTH, then drains in order.
        do_reset();
        dec_ready = 1'b0;
        repeat (6) tick();
        settle();
        check("full_req_low", 32'(imem_req), 32'd0);
        check("full_head_pc", 32'(dec_pc), 32'h0);
        advance();
        dec_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            settle();
            check("drain_pc", 32'(dec_pc), 32'(i));
            advance();
        end
        repeat (4) tick();

        // Absolute branch with 3 queued, 1 in flight, and a simultaneous pop.
        do_reset();
        dec_ready = 1'b0;
        repeat (4) tick();
        dec_ready = 1'b1;
        branch_to(1'b0, 16'h0000, 16'h0040);
        settle();
        check("flush_valid_low", 32'(dec_valid), 32'd0);
        check("br_target_addr", 32'(imem_addr), 32'h0040);
        advance();
        tick();
        settle();
        check("br_abs_pc", 32'(dec_pc), 32'h0040);
        advance();
        repeat (3) tick();

        // Relative branches, including address wrap.
        branch_to(1'b1, 16'h0010, 16'hFFFC);
        repeat (2) tick();
        settle();
        check("br_rel_pc", 32'(dec_pc), 32'h000C);
        advance();
        branch_to(1'b1, 16'hFFFE, 16'h0004);
        repeat (2) tick();
        settle();
        check("br_rel_wrap_pc", 32'(dec_pc), 32'h0002);
        advance();
        branch_to(1'b0, 16'h0000, 16'hFFFF);
        tick();
        settle();
        check("pc_wrap_addr", 32'(imem_addr), 32'h0000);
        advance();
        repeat (4) tick();

        // Halt with one request in flight: it lands and drains, nothing new issues.
        do_reset();
        dec_ready = 1'b1;
        tick();
        halt_ctrl = 1'b1;
        settle();
        check("halt_req_low", 32'(imem_req), 32'd0);
        advance();
        settle();
        check("halt_land_valid", 32'(dec_valid), 32'd1);
        check("halt_land_pc", 32'(dec_pc), 32'h0);
        advance();
        settle();
        check("halt_drained", 32'(dec_valid), 32'd0);
        check("halt_still_low", 32'(imem_req), 32'd0);
        advance();
        halt_ctrl = 1'b0;
        repeat (5) tick();

        // Mid-stream asynchronous reset, asserted between clock edges.
        #3;
        do_reset();
        settle();
        check("rerst_addr", 32'(imem_addr), 32'h0);
        check("rerst_req", 32'(imem_req), 32'd1);
        advance();

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            dec_ready   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) halt_ctrl = ~halt_ctrl;
            branch_ctrl = ($urandom_range(0, 19) == 0);
            branch_mode = 1'($urandom_range(0, 1));
            branch_pc   = ADDR_W'($urandom);
            branch_target = ($urandom_range(0, 3) == 0) ? ADDR_W'(16'hFFF0 + $urandom_range(0, 15))
                                                         : ADDR_W'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
